// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between two requesters,
// returning results over valid/ready and holding the architectural Z/C/N flags.
module alu_arbiter #(
  parameter logic PRIO_FIXED = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp_data,
  output logic       resp_err,
  output logic       alu_optype,
  output logic [3:0] alu_op,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_reg,
  input  logic [7:0] alu_out,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_n,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_n,
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_CMP = 4'hA;
  logic [1:0] state_q, state_d;
  logic       ptr_q, owner_q;
  logic [3:0] op_q;
  logic [7:0] a_q, b_q, data_q;
  logic       err_q, fz_q, fc_q, fn_q;
  logic       idle, exec, win1, grant, legal, hs;
  assign idle  = state_q == IDLE;
  assign exec  = state_q == EXEC;
  // port 1 wins when alone, or on a tie when round-robin points at it
  assign win1  = req1_valid & (~req0_valid | (~PRIO_FIXED & ptr_q));
  assign req0_ready = idle & req0_valid & ~win1;
  assign req1_ready = idle & win1;
  assign grant = req0_ready | req1_ready;
  assign legal = op_q >= OP_ADD && op_q <= OP_CMP;
  assign resp0_valid = state_q == RESP && !owner_q;
  assign resp1_valid = state_q == RESP && owner_q;
  assign hs = (resp0_valid & resp0_ready) | (resp1_valid & resp1_ready);
  assign resp_data  = data_q;
  assign resp_err   = err_q;
  assign alu_optype = ~(exec & legal);
  assign alu_op     = op_q;
  assign alu_acc    = a_q;
  assign alu_reg    = b_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_n = fn_q;
  assign busy   = ~idle;
  always_comb
    state_d = idle ? (grant ? EXEC : IDLE) : exec ? RESP : (hs ? IDLE : RESP);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      op_q    <= 4'h0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
      fz_q    <= 1'b0;
      fc_q    <= 1'b0;
      fn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= req1_ready;
        ptr_q   <= ~req1_ready;
        op_q    <= req1_ready ? req1_op : req0_op;
        a_q     <= req1_ready ? req1_a : req0_a;
        b_q     <= req1_ready ? req1_b : req0_b;
      end
      if (exec) begin
        data_q <= legal && op_q != OP_CMP ? alu_out : 8'h00;
        err_q  <= ~legal;
        if (op_q == OP_ADD || op_q == OP_SUB) fc_q <= alu_c;
        if (op_q == OP_CMP) begin
          fz_q <= alu_z;
          fn_q <= alu_n;
        end
      end
    end
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 8-bit combinational ALU between two requesters: port 0 is the core execute stage, port 1 is the auxiliary/helper engine. The block arbitrates, latches operands, drives the ALU for exactly one cycle, and captures the result and flags. It returns the response over a valid/ready handshake and keeps the architectural Z/C/N flag register. It sits between the requesters and the ALU and is the only driver of the ALU inputs.

Parameters:
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins a simultaneous request.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle (combinational from valids, state, pointer)
req0_op / req1_op  in  4  ALU opcode
req0_a / req1_a  in  8  accumulator operand
req0_b / req1_b  in  8  register operand
resp0_valid / resp1_valid  out  1  result available
resp0_ready / resp1_ready  in  1  requester takes result
resp_data  out  8  result, shared, qualified by respN_valid
resp_err  out  1  illegal opcode, qualified by respN_valid
alu_optype  out  1  0 = ALU active, 1 = ALU idle
alu_op  out  4  to ALU OP
alu_acc / alu_reg  out  8  to ALU acc_in / reg_in
alu_out  in  8  ALU OUT
alu_z / alu_c / alu_n  in  1  ALU flags
flag_z / flag_c / flag_n  out  1  architectural flag register
busy  out  1  state != IDLE

Behaviour:
- Reset state: state = IDLE, pointer = port 0, all resp*_valid = 0, resp_data = 0, resp_err = 0, flags = 0, alu_optype = 1, alu_op/alu_acc/alu_reg = 0. Reset in any state aborts the operation in flight. No response is issued for it, and flags are not updated.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: readyN = 1 only for the winner. Winner rules:
  - Only one port valid: that port wins.
  - Both valid, round-robin: the port named by the pointer wins.
  - Both valid, PRIO_FIXED = 1: port 0 wins.
  - On a transfer (valid & ready), latch op/a/b and the owner id, set the pointer to the other port, and go to EXEC.
- EXEC (1 cycle): drive alu_optype = 0, alu_op, alu_acc, alu_reg from latches. At the clock edge:
  - resp_data <= alu_out.
  - Flags:
    - op 0010 add / 0011 sub: flag_c <= alu_c.
    - op 1010 cmp: flag_z <= alu_z, flag_n <= alu_n, resp_data <= 0.
    - All other legal ops: flags unchanged.
  - Legal ops are 0010–1010. Any other op: do not activate the ALU (optype stays 1), resp_data <= 0, resp_err <= 1, flags unchanged.
  - Go to RESP.
- RESP: resp_valid of the owner = 1, the other port = 0. Outputs are held stable until respN_ready. On a handshake, go to IDLE. No new request is accepted in that same cycle.
- Latency: accept at cycle T, EXEC at T+1, respN_valid high at T+2. The earliest next accept is the cycle after the response handshake. Peak throughput is one op per 3 cycles.
- Outside EXEC: alu_optype = 1, so the ALU latch holds; alu_acc/alu_reg/alu_op keep their last values.
- Request inputs that change while not ready are ignored. A request withdrawn before acceptance is simply not serviced.
- The ALU v output is unused. The flag register has no V bit.
- Shift amount, add/sub wraparound and popcount semantics are entirely the ALU's; the block passes 8-bit values unmodified.

Test Plan:
- Single add on port 0, a=200, b=100:
  - req0_ready at T.
  - resp0_valid at T+2 with resp_data=44, flag_c=1, resp_err=0.
  - Hold resp0_ready low 3 cycles: data stays 44 and busy stays 1 throughout.
- Compare on port 1, a=5, b=9:
  - Response shows resp_data=0, flag_n=1, flag_z=0.
  - Then a=7, b=7: flag_z=1, flag_n=0, and flag_c is unchanged from the prior add.
- Both ports valid every cycle with back-to-back requests, PRIO_FIXED=0:
  - Grants alternate 0,1,0,1.
  - Each response goes only to its owner; the non-owner's resp_valid stays 0.
  - With PRIO_FIXED=1, port 0 wins every time.
- Illegal op 1111 on port 0:
  - resp_err=1, resp_data=0.
  - Flags unchanged, alu_optype stays 1 through EXEC.
- Popcount 1001, b=8'hB7: resp_data=6, flags unchanged.
- Shift left 0100, a=8'h81, b=1: resp_data=8'h02.
- rst_n low during EXEC and again during RESP:
  - Next cycle state=IDLE, resp*_valid=0, flags=0, pointer=port 0.
  - No stale response appears after reset release.
